// File: rtl/test_pattern_sched_if.sv
// test_pattern_sched_if: control, generator-snoop and status signals of the test-pattern run scheduler.
interface test_pattern_sched_if #(
  parameter int GAP_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   cfg_start;
  logic                   cfg_stop;
  logic [COUNT_WIDTH-1:0] cfg_packet_count;
  logic [GAP_WIDTH-1:0]   cfg_gap;
  logic                   mon_tvalid;
  logic                   mon_tready;
  logic                   mon_tlast;
  logic                   gen_enable;
  logic [COUNT_WIDTH-1:0] gen_packet_index;
  logic [COUNT_WIDTH-1:0] sent_count;
  logic                   busy;
  logic                   gap_active;
  logic                   done;
  modport master (
    output cfg_start, cfg_stop, cfg_packet_count, cfg_gap, mon_tvalid, mon_tready, mon_tlast,
    input  gen_enable, gen_packet_index, sent_count, busy, gap_active, done
  );
  modport slave (
    input  cfg_start, cfg_stop, cfg_packet_count, cfg_gap, mon_tvalid, mon_tready, mon_tlast,
    output gen_enable, gen_packet_index, sent_count, busy, gap_active, done
  );
endinterface

// File: rtl/test_pattern_sched.sv
// test_pattern_sched: start/stop run control with packet budget and programmable inter-packet gap.
module test_pattern_sched #(
  parameter int GAP_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  test_pattern_sched_if.slave s_if
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t                 r_state, w_next;
  logic [COUNT_WIDTH-1:0] r_count, r_sent, r_idx, w_sent_inc;
  logic [GAP_WIDTH-1:0]   r_gap, r_gap_cnt;
  logic                   r_stop_pend, r_done;
  logic                   w_eop, w_start, w_end;
  assign w_eop      = s_if.mon_tvalid & s_if.mon_tready & s_if.mon_tlast;
  assign w_sent_inc = r_sent + COUNT_WIDTH'(1);
  assign w_start    = (r_state == IDLE) & s_if.cfg_start & ~s_if.cfg_stop;
  // A stop in SEND only ends the run at a packet boundary; in GAP it ends immediately.
  assign w_end = ((r_state == SEND) & w_eop &
                  (r_stop_pend | s_if.cfg_stop | ((r_count != '0) & (w_sent_inc == r_count)))) |
                 ((r_state == GAP) & s_if.cfg_stop);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? SEND : IDLE;
      SEND:    w_next = w_end ? IDLE : (w_eop && r_gap != '0) ? GAP : SEND;
      GAP:     w_next = w_end ? IDLE : (r_gap_cnt == GAP_WIDTH'(1)) ? SEND : GAP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_sent      <= '0;
      r_idx       <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_end;
      if (w_start) begin
        r_count     <= s_if.cfg_packet_count;
        r_gap       <= s_if.cfg_gap;
        r_sent      <= '0;
        r_idx       <= '0;
        r_stop_pend <= 1'b0;
      end
      if (r_state == SEND && s_if.cfg_stop) r_stop_pend <= 1'b1;
      if (r_state == SEND && w_eop) begin
        r_sent <= w_sent_inc;
        r_idx  <= r_idx + COUNT_WIDTH'(1);
      end
      r_gap_cnt <= (r_state == SEND && w_next == GAP) ? r_gap :
                   (r_state == GAP) ? r_gap_cnt - GAP_WIDTH'(1) : r_gap_cnt;
    end
  end
  assign s_if.gen_enable       = (r_state == SEND);
  assign s_if.gap_active       = (r_state == GAP);
  assign s_if.busy             = (r_state != IDLE);
  assign s_if.done             = r_done;
  assign s_if.sent_count       = r_sent;
  assign s_if.gen_packet_index = r_idx;
endmodule

// File: tb/tb_test_pattern_sched.sv
// tb_test_pattern_sched: directed scoreboard bench for the test-pattern run scheduler.
module tb_test_pattern_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   n_en = 0;
  int   n_gap = 0;
  logic [15:0] q_idx[$];
  test_pattern_sched_if #(.GAP_WIDTH(32), .COUNT_WIDTH(16)) bus ();
  test_pattern_sched #(.GAP_WIDTH(32), .COUNT_WIDTH(16)) dut (.clk(clk), .rst(rst), .s_if(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.gen_enable) n_en++;
    if (bus.gap_active) n_gap++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [15:0] cnt, input logic [31:0] gap);
    bus.cfg_packet_count = cnt;
    bus.cfg_gap          = gap;
    bus.cfg_start        = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    chk("start_enable", bus.gen_enable, 1);
    chk("start_sent", bus.sent_count, 0);
  endtask
  task automatic send_pkt(input int beats, input int stop_beat, input bit stall, output int gap_cyc);
    int          waited;
    logic [15:0] exp;
    waited  = 0;
    gap_cyc = 0;
    while (!bus.gen_enable && waited < 500) begin
      if (bus.gap_active) gap_cyc++;
      waited++;
      tick();
    end
    chk("enable_wait", bus.gen_enable, 1);
    exp = (q_idx.size() != 0) ? q_idx.pop_front() : 16'hdead;
    chk("pkt_index", bus.gen_packet_index, exp);
    if (stall) begin
      bus.mon_tvalid = 1'b1;
      bus.mon_tlast  = 1'b1;
      bus.mon_tready = 1'b0;
      tick();
      chk("stall_ignored", bus.sent_count, exp);
    end
    for (int b = 1; b <= beats; b++) begin
      bus.mon_tvalid = 1'b1;
      bus.mon_tready = 1'b1;
      bus.mon_tlast  = (b == beats);
      bus.cfg_stop   = (b == stop_beat);
      tick();
    end
    bus.mon_tvalid = 1'b0;
    bus.mon_tready = 1'b0;
    bus.mon_tlast  = 1'b0;
    bus.cfg_stop   = 1'b0;
    exp = exp + 16'd1;
    chk("sent_after_eop", bus.sent_count, exp);
  endtask
  initial begin
    int g, d0, e0, a0;
    bus.cfg_start = 0; bus.cfg_stop = 0; bus.cfg_packet_count = 0; bus.cfg_gap = 0;
    bus.mon_tvalid = 0; bus.mon_tready = 0; bus.mon_tlast = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_enable", bus.gen_enable, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_gap", bus.gap_active, 0);
    chk("rst_sent", bus.sent_count, 0);
    chk("rst_index", bus.gen_packet_index, 0);
    // budget 3, gap 10
    d0 = n_done;
    start(16'd3, 32'd10);
    for (int i = 0; i < 3; i++) q_idx.push_back(16'(i));
    send_pkt(1, 0, 1, g);
    chk("t1_gap0", g, 0);
    send_pkt(1, 0, 0, g);
    chk("t1_gap1", g, 10);
    send_pkt(1, 0, 0, g);
    chk("t1_gap2", g, 10);
    chk("t1_done", bus.done, 1);
    chk("t1_busy", bus.busy, 0);
    chk("t1_sent", bus.sent_count, 3);
    tick();
    chk("t1_done_fall", bus.done, 0);
    chk("t1_done_count", n_done - d0, 1);
    // start and stop together, then stop alone
    bus.cfg_start = 1; bus.cfg_stop = 1;
    tick();
    bus.cfg_start = 0;
    chk("startstop_busy", bus.busy, 0);
    tick();
    bus.cfg_stop = 0;
    chk("stop_idle_busy", bus.busy, 0);
    chk("stop_idle_done", bus.done, 0);
    // back-to-back, budget 4
    d0 = n_done; e0 = n_en; a0 = n_gap;
    start(16'd4, 32'd0);
    for (int i = 0; i < 4; i++) q_idx.push_back(16'(i));
    for (int i = 0; i < 4; i++) begin
      send_pkt(1, 0, 0, g);
      chk("t2_no_gap", g, 0);
    end
    chk("t2_done", bus.done, 1);
    chk("t2_sent", bus.sent_count, 4);
    tick();
    chk("t2_enable_cycles", n_en - e0, 4);
    chk("t2_gap_cycles", n_gap - a0, 0);
    chk("t2_done_count", n_done - d0, 1);
    // start while busy is ignored
    start(16'd2, 32'd0);
    q_idx.push_back(16'd0); q_idx.push_back(16'd1);
    send_pkt(1, 0, 0, g);
    bus.cfg_start = 1; bus.cfg_packet_count = 16'd5; bus.cfg_gap = 32'd7;
    tick();
    bus.cfg_start = 0;
    chk("restart_busy", bus.busy, 1);
    chk("restart_sent", bus.sent_count, 1);
    send_pkt(1, 0, 0, g);
    chk("restart_gap", g, 0);
    chk("restart_done", bus.done, 1);
    tick();
    // continuous, 3-beat packets, stop on beat 2 of packet 5
    d0 = n_done;
    start(16'd0, 32'd2);
    for (int i = 0; i < 6; i++) q_idx.push_back(16'(i));
    for (int i = 0; i < 5; i++) begin
      send_pkt(3, 0, 0, g);
      chk("t3_gap", g, (i == 0) ? 0 : 2);
    end
    send_pkt(3, 2, 0, g);
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_sent", bus.sent_count, 6);
    e0 = n_en;
    repeat (20) tick();
    chk("t3_no_enable", n_en - e0, 0);
    chk("t3_done_count", n_done - d0, 1);
    // stop in the middle of a 100-cycle gap
    start(16'd0, 32'd100);
    q_idx.push_back(16'd0);
    send_pkt(1, 0, 0, g);
    chk("t4_gap_active", bus.gap_active, 1);
    repeat (39) tick();
    chk("t4_gap_still", bus.gap_active, 1);
    bus.cfg_stop = 1;
    tick();
    bus.cfg_stop = 0;
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 1);
    chk("t4_gap_off", bus.gap_active, 0);
    chk("t4_sent", bus.sent_count, 1);
    tick();
    // reset while sending aborts without done
    d0 = n_done;
    start(16'd0, 32'd0);
    q_idx.push_back(16'd0);
    send_pkt(1, 0, 0, g);
    bus.mon_tvalid = 1; bus.mon_tready = 1;
    rst = 1'b1;
    tick();
    bus.mon_tvalid = 0; bus.mon_tready = 0;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_enable", bus.gen_enable, 0);
    chk("rst_mid_sent", bus.sent_count, 0);
    chk("rst_mid_index", bus.gen_packet_index, 0);
    chk("rst_mid_done", bus.done, 0);
    rst = 1'b0;
    tick(); tick();
    chk("rst_mid_no_done", n_done - d0, 0);
    // continuous wrap of the 16-bit counters
    start(16'd0, 32'd0);
    bus.mon_tvalid = 1; bus.mon_tready = 1; bus.mon_tlast = 1;
    repeat (65536) tick();
    chk("wrap_sent0", bus.sent_count, 0);
    chk("wrap_index0", bus.gen_packet_index, 0);
    chk("wrap_busy0", bus.busy, 1);
    tick();
    chk("wrap_sent1", bus.sent_count, 1);
    chk("wrap_index1", bus.gen_packet_index, 1);
    chk("wrap_busy1", bus.busy, 1);
    chk("wrap_enable", bus.gen_enable, 1);
    bus.cfg_stop = 1;
    tick();
    bus.cfg_stop = 0; bus.mon_tvalid = 0; bus.mon_tready = 0; bus.mon_tlast = 0;
    chk("wrap_stop_done", bus.done, 1);
    chk("wrap_stop_sent", bus.sent_count, 2);
    chk("wrap_stop_busy", bus.busy, 0);
    chk("queue_empty", q_idx.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
